mig_rd_arbiter: RTL and testbench
=================================

Name: mig_rd_arbiter

Overview:
- Two-master to one-slave arbiter for the read channels (AR/R) of the MIG AXI port (`mem_axi_ar*`/`mem_axi_r*`, 7-bit ID, 32-bit addr/data, 8-bit len) in the `mig_clk` domain.
- Master 0 is the SoC interconnect read path; master 1 is a display/DMA read engine.
- Allows one outstanding read burst at a time: the grant is held from AR acceptance until the last R beat.
- Checks every burst's beat count against its `arlen`.

Parameters:
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority to the master chosen by PRIO_M1.
- PRIO_M1, 0, fixed-priority winner when RR_EN=0 (0 = master 0, 1 = master 1).

Ports:
- mig_clk  input  1  MIG UI clock; all logic is clocked on its rising edge.
- mig_rst  input  1  Asynchronous, active-high reset.
- sN_arid / sN_araddr / sN_arlen / sN_arsize / sN_arburst  input  7/32/8/3/2  Master N AR payload (N = 0, 1).
- sN_arvalid  input  1  Master N AR valid.
- sN_arready  output  1  Master N AR ready.
- sN_rid / sN_rdata / sN_rresp  output  7/32/2  Master N R payload.
- sN_rlast / sN_rvalid  output  1/1  Master N R last and valid.
- sN_rready  input  1  Master N R ready.
- mem_axi_arid / araddr / arlen / arsize / arburst  output  7/32/8/3/2  AR payload to MIG.
- mem_axi_arvalid  output  1  AR valid to MIG.
- mem_axi_arready  input  1  AR ready from MIG.
- mem_axi_rid / rdata / rresp / rlast / rvalid  input  7/32/2/1/1  R channel from MIG.
- mem_axi_rready  output  1  R ready to MIG.
- busy  output  1  High whenever the state is not IDLE.
- grant  output  1  Index of the master currently granted; valid while busy=1.
- protocol_err  output  1  Sticky error flag; cleared only by reset.

Behaviour:
- States:
  - IDLE: no master granted.
  - ADDR: granted master's AR is presented to the MIG.
  - DATA: R beats of the accepted burst are routed back to the granted master.
- Reset (asynchronous, takes effect immediately, including mid-burst):
  - State goes to IDLE; last_grant=1, so master 0 wins the first round-robin contest.
  - beat_cnt=0; grant=0; busy=0; protocol_err=0.
  - mem_axi_arvalid=0, mem_axi_rready=0, s0/s1_arready=0, s0/s1_rvalid=0.
  - No attempt is made to drain an in-flight burst; the MIG is reset from the same source.
- IDLE:
  - Any sN_arvalid moves the state to ADDR next cycle, with grant registered.
  - Single requester: that requester wins.
  - Both requesting, RR_EN=1: winner is ~last_grant.
  - Both requesting, RR_EN=0: winner is PRIO_M1.
  - All arready and rvalid outputs are 0 in IDLE. Minimum AR latency is 1 cycle from arvalid to mem_axi_arvalid.
- ADDR:
  - mem_axi_ar* and mem_axi_arvalid are driven combinationally from the granted master.
  - s[grant]_arready = mem_axi_arready; the other master's arready is 0.
  - Masters hold arvalid per AXI. If the granted master drops arvalid before the handshake, the arbiter returns to IDLE; this is not an error.
  - On mem_axi_arvalid & mem_axi_arready: latch arlen into len_q, clear beat_cnt, go to DATA.
- DATA:
  - s[grant]_r* = mem_axi_r*; mem_axi_rready = s[grant]_rready.
  - The non-granted master sees rvalid=0.
  - Both sN_arready are 0; new requests wait.
  - Each R handshake increments beat_cnt (8-bit).
  - Handshake with rlast=1: last_grant <= grant, state goes to IDLE. Back-to-back bursts therefore have a 1-cycle IDLE gap.
- Beat-count check:
  - rlast=1 on a beat where beat_cnt != len_q sets protocol_err.
  - A beat with rlast=0 while beat_cnt == len_q also sets protocol_err; the arbiter keeps waiting for rlast.
  - rid mismatch against the latched arid sets protocol_err. Data is still forwarded in all cases.
- Combinational paths: no combinational path from sN_rready to sN_rvalid. AR/R payloads pass through unregistered.
- Simultaneous events: a new request arriving in the same cycle as the final rlast is not granted until the IDLE cycle that follows.
- arlen=255 (256 beats): no overflow; the 8-bit compare is exact.

Test Plan:
- Single read: reset, s0 AR araddr=0x1000, arlen=3; MIG accepts after 2 cycles and returns 4 beats 0xA0..0xA3. Required: s0 gets 4 beats with rlast on the 4th, s1_rvalid stays 0, busy drops 1 cycle after the last beat, protocol_err=0.
- Round-robin: RR_EN=1, both masters request continuously with arlen=0. Required: grant sequence 0,1,0,1 over four bursts, with a 1-cycle IDLE gap between bursts.
- Fixed priority: RR_EN=0, PRIO_M1=1, both requesting continuously. Required: every grant goes to master 1; master 0 starves until s1_arvalid is dropped.
- Backpressure: s1 burst with arlen=7; s1_rready toggles 1,0 every cycle and mem_axi_rvalid is held high. Required: mem_axi_rready mirrors s1_rready, all 8 beats arrive in order, no beat is dropped or duplicated.
- Protocol error: arlen=3, MIG asserts rlast on beat 2. Required: protocol_err=1 and stays 1 after later good bursts; FSM returns to IDLE.
- Reset mid-burst: assert mig_rst during beat 1 of a 4-beat burst. Required: all outputs and state are at reset values on the next sample. After release, s1 then s0 both request; master 0 wins first.

Source files
------------

// File: rtl/mig_rd_arbiter.sv
// Two-master read-channel arbiter in front of the MIG AXI port.
// One burst is outstanding at a time: the grant is taken when a master's AR
// request is seen in IDLE and held until the final R beat of that burst.
// Every burst's beat count and R ID are checked against the accepted AR.
module mig_rd_arbiter #(
    parameter bit RR_EN   = 1'b1,
    parameter bit PRIO_M1 = 1'b0
) (
    input  logic        mig_clk,
    input  logic        mig_rst,

    input  logic [6:0]  s0_arid,
    input  logic [31:0] s0_araddr,
    input  logic [7:0]  s0_arlen,
    input  logic [2:0]  s0_arsize,
    input  logic [1:0]  s0_arburst,
    input  logic        s0_arvalid,
    output logic        s0_arready,
    output logic [6:0]  s0_rid,
    output logic [31:0] s0_rdata,
    output logic [1:0]  s0_rresp,
    output logic        s0_rlast,
    output logic        s0_rvalid,
    input  logic        s0_rready,

    input  logic [6:0]  s1_arid,
    input  logic [31:0] s1_araddr,
    input  logic [7:0]  s1_arlen,
    input  logic [2:0]  s1_arsize,
    input  logic [1:0]  s1_arburst,
    input  logic        s1_arvalid,
    output logic        s1_arready,
    output logic [6:0]  s1_rid,
    output logic [31:0] s1_rdata,
    output logic [1:0]  s1_rresp,
    output logic        s1_rlast,
    output logic        s1_rvalid,
    input  logic        s1_rready,

    output logic [6:0]  mem_axi_arid,
    output logic [31:0] mem_axi_araddr,
    output logic [7:0]  mem_axi_arlen,
    output logic [2:0]  mem_axi_arsize,
    output logic [1:0]  mem_axi_arburst,
    output logic        mem_axi_arvalid,
    input  logic        mem_axi_arready,
    input  logic [6:0]  mem_axi_rid,
    input  logic [31:0] mem_axi_rdata,
    input  logic [1:0]  mem_axi_rresp,
    input  logic        mem_axi_rlast,
    input  logic        mem_axi_rvalid,
    output logic        mem_axi_rready,

    output logic        busy,
    output logic        grant,
    output logic        protocol_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;
    logic        perr_q, perr_d;
    logic [7:0]  len_q, len_d;
    logic [6:0]  id_q, id_d;

    logic        sel_arvalid;
    logic        sel_rready;
    logic        r_hs;
    logic        beat_bad;

    // Arbitration among simultaneous requesters; a lone requester always wins.
    function automatic logic pick_master(input logic req0, input logic req1,
                                         input logic last);
        if (req0 && req1) begin
            return RR_EN ? ~last : PRIO_M1;
        end
        return req1;
    endfunction

    // Address payload follows the granted master; R payload fans out to both.
    assign sel_arvalid     = grant_q ? s1_arvalid : s0_arvalid;
    assign sel_rready      = grant_q ? s1_rready  : s0_rready;
    assign mem_axi_arid    = grant_q ? s1_arid    : s0_arid;
    assign mem_axi_araddr  = grant_q ? s1_araddr  : s0_araddr;
    assign mem_axi_arlen   = grant_q ? s1_arlen   : s0_arlen;
    assign mem_axi_arsize  = grant_q ? s1_arsize  : s0_arsize;
    assign mem_axi_arburst = grant_q ? s1_arburst : s0_arburst;

    assign s0_rid   = mem_axi_rid;
    assign s0_rdata = mem_axi_rdata;
    assign s0_rresp = mem_axi_rresp;
    assign s0_rlast = mem_axi_rlast;
    assign s1_rid   = mem_axi_rid;
    assign s1_rdata = mem_axi_rdata;
    assign s1_rresp = mem_axi_rresp;
    assign s1_rlast = mem_axi_rlast;

    assign r_hs = mem_axi_rvalid & mem_axi_rready;

    // A beat is bad if rlast disagrees with the expected final beat, or the ID
    // does not match the accepted request.
    assign beat_bad = (mem_axi_rlast != (beat_cnt_q == len_q)) || (mem_axi_rid != id_q);

    assign busy         = (state_q != IDLE);
    assign grant        = grant_q;
    assign protocol_err = perr_q;

    // Control state register; reset abandons any in-flight burst.
    always_ff @(posedge mig_clk or posedge mig_rst) begin
        if (mig_rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= 8'd0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            perr_q       <= perr_d;
        end
    end

    // Accepted burst length and ID; only meaningful while in DATA.
    always_ff @(posedge mig_clk) begin
        len_q <= len_d;
        id_q  <= id_d;
    end

    // Next-state and bookkeeping for the grant/burst lifecycle.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        perr_d       = perr_q;
        len_d        = len_q;
        id_d         = id_q;
        case (state_q)
            IDLE: begin
                if (s0_arvalid || s1_arvalid) begin
                    state_d = ADDR;
                    grant_d = pick_master(s0_arvalid, s1_arvalid, last_grant_q);
                end
            end
            ADDR: begin
                if (!sel_arvalid) begin
                    state_d = IDLE;
                end else if (mem_axi_arready) begin
                    len_d      = mem_axi_arlen;
                    id_d       = mem_axi_arid;
                    beat_cnt_d = 8'd0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (r_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_bad) begin
                        perr_d = 1'b1;
                    end
                    if (mem_axi_rlast) begin
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake steering: only the granted master sees ready/valid.
    always_comb begin
        mem_axi_arvalid = 1'b0;
        mem_axi_rready  = 1'b0;
        s0_arready      = 1'b0;
        s1_arready      = 1'b0;
        s0_rvalid       = 1'b0;
        s1_rvalid       = 1'b0;
        case (state_q)
            ADDR: begin
                mem_axi_arvalid = sel_arvalid;
                s0_arready      = ~grant_q & mem_axi_arready;
                s1_arready      = grant_q & mem_axi_arready;
            end
            DATA: begin
                mem_axi_rready = sel_rready;
                s0_rvalid      = ~grant_q & mem_axi_rvalid;
                s1_rvalid      = grant_q & mem_axi_rvalid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mig_rd_arbiter.sv
// Directed bench for mig_rd_arbiter: a round-robin instance plus a
// fixed-priority (master 1) instance sharing the same stimulus.
module tb_mig_rd_arbiter;

    logic        mig_clk = 1'b0;
    logic        mig_rst;

    logic [6:0]  s0_arid, s1_arid;
    logic [31:0] s0_araddr, s1_araddr;
    logic [7:0]  s0_arlen, s1_arlen;
    logic [2:0]  s0_arsize, s1_arsize;
    logic [1:0]  s0_arburst, s1_arburst;
    logic        s0_arvalid, s1_arvalid, s0_rready, s1_rready;
    logic        mem_axi_arready;
    logic [6:0]  mem_axi_rid;
    logic [31:0] mem_axi_rdata;
    logic [1:0]  mem_axi_rresp;
    logic        mem_axi_rlast, mem_axi_rvalid;

    logic        s0_arready, s1_arready;
    logic [6:0]  s0_rid, s1_rid;
    logic [31:0] s0_rdata, s1_rdata;
    logic [1:0]  s0_rresp, s1_rresp;
    logic        s0_rlast, s1_rlast, s0_rvalid, s1_rvalid;
    logic [6:0]  mem_axi_arid;
    logic [31:0] mem_axi_araddr;
    logic [7:0]  mem_axi_arlen;
    logic [2:0]  mem_axi_arsize;
    logic [1:0]  mem_axi_arburst;
    logic        mem_axi_arvalid, mem_axi_rready, busy, grant, protocol_err;

    logic        fp_s0_arready, fp_s1_arready;
    logic [6:0]  fp_s0_rid, fp_s1_rid;
    logic [31:0] fp_s0_rdata, fp_s1_rdata;
    logic [1:0]  fp_s0_rresp, fp_s1_rresp;
    logic        fp_s0_rlast, fp_s1_rlast, fp_s0_rvalid, fp_s1_rvalid;
    logic [6:0]  fp_arid;
    logic [31:0] fp_araddr;
    logic [7:0]  fp_arlen;
    logic [2:0]  fp_arsize;
    logic [1:0]  fp_arburst;
    logic        fp_arvalid, fp_rready, fp_busy, fp_grant, fp_protocol_err;

    int   n_chk  = 0;
    int   n_fail = 0;
    logic err_m  = 1'b0;
    int   nbeats;

    always #5 mig_clk = ~mig_clk;

    mig_rd_arbiter #(.RR_EN(1'b1), .PRIO_M1(1'b0)) dut (
        .mig_clk(mig_clk), .mig_rst(mig_rst),
        .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
        .s0_arsize(s0_arsize), .s0_arburst(s0_arburst), .s0_arvalid(s0_arvalid),
        .s0_arready(s0_arready), .s0_rid(s0_rid), .s0_rdata(s0_rdata),
        .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
        .s1_arsize(s1_arsize), .s1_arburst(s1_arburst), .s1_arvalid(s1_arvalid),
        .s1_arready(s1_arready), .s1_rid(s1_rid), .s1_rdata(s1_rdata),
        .s1_rresp(s1_rresp), .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .mem_axi_arid(mem_axi_arid), .mem_axi_araddr(mem_axi_araddr), .mem_axi_arlen(mem_axi_arlen),
        .mem_axi_arsize(mem_axi_arsize), .mem_axi_arburst(mem_axi_arburst),
        .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
        .mem_axi_rid(mem_axi_rid), .mem_axi_rdata(mem_axi_rdata), .mem_axi_rresp(mem_axi_rresp),
        .mem_axi_rlast(mem_axi_rlast), .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
        .busy(busy), .grant(grant), .protocol_err(protocol_err)
    );

    mig_rd_arbiter #(.RR_EN(1'b0), .PRIO_M1(1'b1)) dut_fp (
        .mig_clk(mig_clk), .mig_rst(mig_rst),
        .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
        .s0_arsize(s0_arsize), .s0_arburst(s0_arburst), .s0_arvalid(s0_arvalid),
        .s0_arready(fp_s0_arready), .s0_rid(fp_s0_rid), .s0_rdata(fp_s0_rdata),
        .s0_rresp(fp_s0_rresp), .s0_rlast(fp_s0_rlast), .s0_rvalid(fp_s0_rvalid), .s0_rready(s0_rready),
        .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
        .s1_arsize(s1_arsize), .s1_arburst(s1_arburst), .s1_arvalid(s1_arvalid),
        .s1_arready(fp_s1_arready), .s1_rid(fp_s1_rid), .s1_rdata(fp_s1_rdata),
        .s1_rresp(fp_s1_rresp), .s1_rlast(fp_s1_rlast), .s1_rvalid(fp_s1_rvalid), .s1_rready(s1_rready),
        .mem_axi_arid(fp_arid), .mem_axi_araddr(fp_araddr), .mem_axi_arlen(fp_arlen),
        .mem_axi_arsize(fp_arsize), .mem_axi_arburst(fp_arburst),
        .mem_axi_arvalid(fp_arvalid), .mem_axi_arready(mem_axi_arready),
        .mem_axi_rid(mem_axi_rid), .mem_axi_rdata(mem_axi_rdata), .mem_axi_rresp(mem_axi_rresp),
        .mem_axi_rlast(mem_axi_rlast), .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(fp_rready),
        .busy(fp_busy), .grant(fp_grant), .protocol_err(fp_protocol_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge mig_clk);
        #1;
    endtask

    task automatic clear_inputs;
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;
        s0_rready = 1'b0; s1_rready = 1'b0;
        mem_axi_arready = 1'b0; mem_axi_rvalid = 1'b0; mem_axi_rlast = 1'b0;
        mem_axi_rid = 7'd0; mem_axi_rdata = 32'd0; mem_axi_rresp = 2'd0;
    endtask

    task automatic rst_pulse;
        clear_inputs();
        mig_rst = 1'b1;
        cyc();
        mig_rst = 1'b0;
        err_m = 1'b0;
    endtask

    // One burst from master m; MIG accepts AR after ar_wait cycles and sends
    // beats 0..last_at (rlast on last_at) with the given rid.
    task automatic burst(input logic m, input logic [6:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input int last_at, input logic [6:0] rid,
                         input int ar_wait);
        if (m) begin
            s1_arvalid = 1'b1; s1_arid = id; s1_araddr = addr; s1_arlen = len;
        end else begin
            s0_arvalid = 1'b1; s0_arid = id; s0_araddr = addr; s0_arlen = len;
        end
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_arready", s0_arready | s1_arready, 0);
        cyc();
        for (int w = 0; w <= ar_wait; w++) begin
            mem_axi_arready = (w == ar_wait);
            #1;
            chk("addr_busy", busy, 1);
            chk("addr_grant", grant, m);
            chk("ar_valid", mem_axi_arvalid, 1);
            chk("ar_addr", mem_axi_araddr, addr);
            chk("ar_len", mem_axi_arlen, len);
            chk("ar_id", mem_axi_arid, id);
            chk("ar_size", mem_axi_arsize, m ? 3 : 2);
            chk("ar_ready_sel", m ? s1_arready : s0_arready, w == ar_wait);
            chk("ar_ready_other", m ? s0_arready : s1_arready, 0);
            cyc();
        end
        s0_arvalid = 1'b0; s1_arvalid = 1'b0; mem_axi_arready = 1'b0;
        for (int b = 0; b <= last_at; b++) begin
            mem_axi_rvalid = 1'b1; mem_axi_rdata = 32'hA0 + b; mem_axi_rid = rid;
            mem_axi_rresp = 2'(b); mem_axi_rlast = (b == last_at);
            s0_rready = 1'b1; s1_rready = 1'b1;
            #1;
            chk("data_busy", busy, 1);
            chk("r_valid_sel", m ? s1_rvalid : s0_rvalid, 1);
            chk("r_valid_other", m ? s0_rvalid : s1_rvalid, 0);
            chk("r_data", m ? s1_rdata : s0_rdata, 32'hA0 + b);
            chk("r_resp", m ? s1_rresp : s0_rresp, b % 4);
            chk("r_last", m ? s1_rlast : s0_rlast, b == last_at);
            chk("mem_rready", mem_axi_rready, 1);
            chk("perr_beat", protocol_err, err_m);
            err_m = err_m | (rid != id) | ((b == last_at) != (b == int'(len)));
            cyc();
        end
        clear_inputs();
        #1;
        chk("end_busy", busy, 0);
        chk("end_perr", protocol_err, err_m);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        mig_rst = 1'b0;
        s0_arid = 7'd0; s1_arid = 7'd0; s0_araddr = 32'd0; s1_araddr = 32'd0;
        s0_arlen = 8'd0; s1_arlen = 8'd0;
        s0_arsize = 3'd2; s0_arburst = 2'd1; s1_arsize = 3'd3; s1_arburst = 2'd2;
        clear_inputs();
        #1 mig_rst = 1'b1;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_perr", protocol_err, 0);
        chk("rst_arvalid", mem_axi_arvalid, 0);
        chk("rst_rready", mem_axi_rready, 0);
        chk("rst_arready", {s0_arready, s1_arready}, 0);
        chk("rst_rvalid", {s0_rvalid, s1_rvalid}, 0);
        cyc(); cyc();
        mig_rst = 1'b0;

        // Single read from master 0, AR accepted after two wait cycles.
        burst(1'b0, 7'd5, 32'h1000, 8'd3, 3, 7'd5, 2);

        // Both masters request back-to-back single-beat bursts.
        rst_pulse();
        s0_arvalid = 1'b1; s1_arvalid = 1'b1; s0_arid = 7'd3; s1_arid = 7'd3;
        s0_arlen = 8'd0; s1_arlen = 8'd0;
        mem_axi_arready = 1'b1; mem_axi_rvalid = 1'b1; mem_axi_rlast = 1'b1; mem_axi_rid = 7'd3;
        s0_rready = 1'b1; s1_rready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            chk("rr_busy", busy, c % 3 != 0);
            if (c % 3 != 0) chk("rr_grant", grant, (c / 3) % 2);
            chk("fp_busy", fp_busy, c % 3 != 0);
            if (c % 3 != 0) chk("fp_grant", fp_grant, 1);
            chk("fp_s0_arready", fp_s0_arready, 0);
            cyc();
        end
        s1_arvalid = 1'b0;
        #1;
        chk("drop_busy", busy | fp_busy, 0);
        cyc();
        #1;
        chk("m0_grant", grant, 0);
        chk("fp_m0_grant", fp_grant, 0);
        chk("fp_m0_busy", fp_busy, 1);
        cyc();
        s0_arvalid = 1'b0;
        cyc();
        clear_inputs();
        #1;
        chk("rr_end_busy", busy | fp_busy, 0);
        chk("rr_perr", protocol_err, 0);

        // Backpressure: master 1, 8 beats, rready toggling, rvalid held.
        cyc();
        s1_arvalid = 1'b1; s1_arid = 7'd9; s1_araddr = 32'h2000; s1_arlen = 8'd7;
        cyc();
        mem_axi_arready = 1'b1;
        #1;
        chk("bp_grant", grant, 1);
        chk("bp_arready", s1_arready, 1);
        cyc();
        s1_arvalid = 1'b0; mem_axi_arready = 1'b0; mem_axi_rid = 7'd9;
        nbeats = 0;
        for (int i = 0; i < 16; i++) begin
            s1_rready = (i % 2 == 0);
            mem_axi_rvalid = 1'b1; mem_axi_rdata = 32'hB0 + i / 2; mem_axi_rlast = (i / 2 == 7);
            #1;
            chk("bp_rready", mem_axi_rready, i % 2 == 0);
            chk("bp_rvalid", s1_rvalid, i < 15);
            chk("bp_rdata", s1_rdata, 32'hB0 + i / 2);
            chk("bp_s0_rvalid", s0_rvalid, 0);
            if (s1_rvalid && s1_rready) nbeats++;
            cyc();
        end
        clear_inputs();
        #1;
        chk("bp_beats", nbeats, 8);
        chk("bp_busy", busy, 0);
        chk("bp_perr", protocol_err, 0);

        // Early rlast, then a good burst: error stays set.
        rst_pulse();
        burst(1'b0, 7'd2, 32'h3000, 8'd3, 2, 7'd2, 0);
        chk("early_last_perr", protocol_err, 1);
        burst(1'b1, 7'd4, 32'h3100, 8'd0, 0, 7'd4, 0);
        chk("sticky_perr", protocol_err, 1);

        // Missing rlast on the expected final beat; arbiter keeps waiting.
        rst_pulse();
        burst(1'b1, 7'd6, 32'h3200, 8'd1, 2, 7'd6, 0);

        // R ID mismatch.
        rst_pulse();
        burst(1'b0, 7'd1, 32'h3300, 8'd0, 0, 7'd7, 0);

        // Reset during beat 1 of a 4-beat burst from master 1.
        s1_arvalid = 1'b1; s1_arid = 7'd5; s1_arlen = 8'd3;
        cyc();
        mem_axi_arready = 1'b1;
        cyc();
        s1_arvalid = 1'b0; mem_axi_arready = 1'b0;
        mem_axi_rvalid = 1'b1; mem_axi_rdata = 32'hA0; mem_axi_rid = 7'd5; s1_rready = 1'b1;
        cyc();
        mem_axi_rdata = 32'hA1;
        mig_rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_perr", protocol_err, 0);
        chk("mid_rst_arvalid", mem_axi_arvalid, 0);
        chk("mid_rst_rready", mem_axi_rready, 0);
        chk("mid_rst_rvalid", {s0_rvalid, s1_rvalid}, 0);
        chk("mid_rst_arready", {s0_arready, s1_arready}, 0);
        cyc();
        mig_rst = 1'b0;
        clear_inputs();
        s1_arvalid = 1'b1;
        s0_arvalid = 1'b1;
        #1;
        chk("post_rst_idle", busy, 0);
        cyc();
        #1;
        chk("post_rst_grant", grant, 0);
        chk("post_rst_busy", busy, 1);
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;
        cyc();
        #1;
        chk("abandon_busy", busy, 0);
        chk("abandon_perr", protocol_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
